// File: rtl/rv_pkg.sv
// Shared RV64 definitions: base opcodes used by fetch and control, and the
// fetch-stage FSM state encoding.
package rv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/opcode_legal_chk.sv
// Combinational opcode legality check for the fetch stage; present only when
// FETCH_ILLEGAL_CHECK_EN is defined.
`ifdef FETCH_ILLEGAL_CHECK_EN
module opcode_legal_chk
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this block latch-free.
    illegal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IALU: illegal_o = 1'b0;
      default:                                         illegal_o = 1'b1;
    endcase
  end

endmodule
`endif

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch with a one-entry decode buffer and
// branch redirect. Define FETCH_ILLEGAL_CHECK_EN to register an opcode-illegal flag.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [6:0]      dec_opcode,
  output logic [PC_W-1:0] dec_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dec_illegal
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc_d;
  logic            dec_valid_q;
  logic [31:0]     dec_instr_q;
  logic [PC_W-1:0] dec_pc_q;

  assign pc_inc_d = pc_q + PC_W'(4);

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic illegal_d;
  logic dec_illegal_q;

  opcode_legal_chk u_legal_chk (
    .opcode_i  (imem_rsp_data[6:0]),
    .illegal_o (illegal_d)
  );

  assign dec_illegal = dec_illegal_q;
`else
  assign dec_illegal = 1'b0;
`endif

  // Request is suppressed while reset is asserted, whatever the state register holds.
  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_req_addr  = pc_q;
  assign dec_valid      = dec_valid_q;
  assign dec_instr      = dec_instr_q;
  assign dec_opcode     = dec_instr_q[6:0];
  assign dec_pc         = dec_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the decode payload is reset too since it is visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
`ifdef FETCH_ILLEGAL_CHECK_EN
      dec_illegal_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      dec_valid_q <= 1'b0;
      case (state_q)
        S_REQ:   state_q <= imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: if (imem_req_ready) state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_rsp_valid) begin
            dec_instr_q <= imem_rsp_data;
            dec_pc_q    <= pc_q;
            dec_valid_q <= 1'b1;
            pc_q        <= pc_inc_d;
`ifdef FETCH_ILLEGAL_CHECK_EN
            dec_illegal_q <= illegal_d;
`endif
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (dec_valid_q && dec_ready) begin
            dec_valid_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_DROP:  if (imem_rsp_valid) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
